// File: rtl/cordic_angle_reducer.sv
// Angle reducer ahead of the CORDIC core.
// Takes a float32 angle in degrees, reduces it modulo 360, folds the residue
// into [0,90] and reports the quadrant plus sin/cos sign-correction flags.
// The five-bit CHRVE mode tag rides along with every sample. Bypass samples
// are forwarded bit-exact with the same fixed latency of 11 edges.
//
// Handshake: a sample moves on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE, so there is one sample in flight.
// out_valid is high only in DONE; all outputs hold steady until out_ready.
module cordic_angle_reducer #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_angle,
    input  logic [4:0]  in_chrve,
    input  logic        in_bypass,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_angle,
    output logic [4:0]  out_chrve,
    output logic [1:0]  out_quadrant,
    output logic        out_sin_neg,
    output logic        out_cos_neg,
    output logic        out_err,
    output logic [2:0]  dbg_state_o
);

    localparam int W = 16 + FRAC_BITS;
    localparam logic [W-1:0] DEG90  = W'(90)  << FRAC_BITS;
    localparam logic [W-1:0] DEG180 = W'(180) << FRAC_BITS;
    localparam logic [W-1:0] DEG270 = W'(270) << FRAC_BITS;
    localparam logic [W-1:0] DEG360 = W'(360) << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_REDUCE = 3'd2,
        S_FOLD   = 3'd3,
        S_PACK   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [31:0]    raw_q, raw_d;
    logic [4:0]     chrve_q, chrve_d;
    logic           bypass_q, bypass_d;
    logic           err_q, err_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [1:0]     quad_q, quad_d;
    logic           sneg_q, sneg_d;
    logic           cneg_q, cneg_d;
    logic [31:0]    out_angle_q, out_angle_d;
    logic [4:0]     out_chrve_q, out_chrve_d;
    logic [1:0]     out_quad_q, out_quad_d;
    logic           out_sneg_q, out_sneg_d;
    logic           out_cneg_q, out_cneg_d;
    logic           out_err_q, out_err_d;

    // Datapath helpers shared by the FSM below
    logic [7:0]     exp_c;
    logic [7:0]     shamt_c;
    logic [W-1:0]   unpacked_c;
    logic [W-1:0]   step_c;
    logic [W-1:0]   res_c;
    int             msb_c;
    logic [7:0]     pexp_c;
    logic [22:0]    pmant_c;

    // Float-to-fixed, modulo step, sign fold and leading-one pack helpers
    always_comb begin
        exp_c      = raw_q[30:23];
        // 166 - exp aligns the 24-bit significand to Q16.FRAC_BITS; the
        // constant is independent of FRAC_BITS. Dropped bits truncate.
        shamt_c    = 8'd166 - exp_c;
        unpacked_c = W'({1'b1, raw_q[22:0], {W{1'b0}}} >> shamt_c);
        step_c     = DEG360 << k_q;
        // Negative angles map to 360 - R; a zero residue (incl. -0) stays 0.
        res_c      = (raw_q[31] && (mag_q != '0)) ? (DEG360 - mag_q) : mag_q;
        msb_c      = 0;
        for (int i = 0; i < W; i++) begin
            if (mag_q[i]) msb_c = i;
        end
        pexp_c     = 8'(127 + msb_c - FRAC_BITS);
        pmant_c    = 23'(({mag_q, 23'b0} << (W - 1 - msb_c)) >> (W - 1));
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            raw_q       <= '0;
            chrve_q     <= '0;
            bypass_q    <= 1'b0;
            err_q       <= 1'b0;
            mag_q       <= '0;
            quad_q      <= '0;
            sneg_q      <= 1'b0;
            cneg_q      <= 1'b0;
            out_angle_q <= '0;
            out_chrve_q <= '0;
            out_quad_q  <= '0;
            out_sneg_q  <= 1'b0;
            out_cneg_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            raw_q       <= raw_d;
            chrve_q     <= chrve_d;
            bypass_q    <= bypass_d;
            err_q       <= err_d;
            mag_q       <= mag_d;
            quad_q      <= quad_d;
            sneg_q      <= sneg_d;
            cneg_q      <= cneg_d;
            out_angle_q <= out_angle_d;
            out_chrve_q <= out_chrve_d;
            out_quad_q  <= out_quad_d;
            out_sneg_q  <= out_sneg_d;
            out_cneg_q  <= out_cneg_d;
            out_err_q   <= out_err_d;
        end
    end

    // Next-state and datapath updates for each phase of the reduction
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        raw_d       = raw_q;
        chrve_d     = chrve_q;
        bypass_d    = bypass_q;
        err_d       = err_q;
        mag_d       = mag_q;
        quad_d      = quad_q;
        sneg_d      = sneg_q;
        cneg_d      = cneg_q;
        out_angle_d = out_angle_q;
        out_chrve_d = out_chrve_q;
        out_quad_d  = out_quad_q;
        out_sneg_d  = out_sneg_q;
        out_cneg_d  = out_cneg_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    raw_d    = in_angle;
                    chrve_d  = in_chrve;
                    bypass_d = in_bypass;
                    state_d  = S_UNPACK;
                end
            end
            S_UNPACK: begin
                // Inf/NaN and |angle| >= 2^16 are out of range; bypass skips the check.
                err_d   = !bypass_q && ((exp_c == 8'hFF) || (exp_c >= 8'd143));
                // Denormals and zero collapse to a zero magnitude.
                mag_d   = (exp_c == 8'd0) ? '0 : unpacked_c;
                k_d     = 3'd7;
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                // Restoring subtraction of 360*2^k, largest multiple first.
                if (mag_q >= step_c) mag_d = mag_q - step_c;
                k_d = k_q - 3'd1;
                if (k_q == 3'd0) state_d = S_FOLD;
            end
            S_FOLD: begin
                if (res_c < DEG90) begin
                    mag_d  = res_c;
                    quad_d = 2'd0;
                    sneg_d = 1'b0;
                    cneg_d = 1'b0;
                end else if (res_c < DEG180) begin
                    mag_d  = DEG180 - res_c;
                    quad_d = 2'd1;
                    sneg_d = 1'b0;
                    cneg_d = 1'b1;
                end else if (res_c < DEG270) begin
                    mag_d  = res_c - DEG180;
                    quad_d = 2'd2;
                    sneg_d = 1'b1;
                    cneg_d = 1'b1;
                end else begin
                    mag_d  = DEG360 - res_c;
                    quad_d = 2'd3;
                    sneg_d = 1'b1;
                    cneg_d = 1'b0;
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                out_chrve_d = chrve_q;
                if (bypass_q) begin
                    out_angle_d = raw_q;
                    out_quad_d  = 2'd0;
                    out_sneg_d  = 1'b0;
                    out_cneg_d  = 1'b0;
                    out_err_d   = 1'b0;
                end else if (err_q) begin
                    out_angle_d = '0;
                    out_quad_d  = 2'd0;
                    out_sneg_d  = 1'b0;
                    out_cneg_d  = 1'b0;
                    out_err_d   = 1'b1;
                end else begin
                    out_angle_d = (mag_q == '0) ? 32'd0 : {1'b0, pexp_c, pmant_c};
                    out_quad_d  = quad_q;
                    out_sneg_d  = sneg_q;
                    out_cneg_d  = cneg_q;
                    out_err_d   = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_angle    = out_angle_q;
    assign out_chrve    = out_chrve_q;
    assign out_quadrant = out_quad_q;
    assign out_sin_neg  = out_sneg_q;
    assign out_cos_neg  = out_cneg_q;
    assign out_err      = out_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Bench for cordic_angle_reducer: directed vectors with hand-derived results,
// randomized vectors against a real-arithmetic reference model, backpressure
// and mid-flight reset. A monitor pops the expected queue on each transfer.
module tb_cordic_angle_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic [4:0]  in_chrve;
    logic        in_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_angle;
    logic [4:0]  out_chrve;
    logic [1:0]  out_quadrant;
    logic        out_sin_neg;
    logic        out_cos_neg;
    logic        out_err;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic prev_valid = 1'b0;

    // expected word: {angle[31:0], chrve[4:0], quadrant[1:0], sin_neg, cos_neg, err}
    logic [41:0] exp_q[$];
    int          acc_q[$];

    cordic_angle_reducer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_angle     (in_angle),
        .in_chrve     (in_chrve),
        .in_bypass    (in_bypass),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_angle    (out_angle),
        .out_chrve    (out_chrve),
        .out_quadrant (out_quadrant),
        .out_sin_neg  (out_sin_neg),
        .out_cos_neg  (out_cos_neg),
        .out_err      (out_err),
        .dbg_state_o  (dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // real value to float32 bits (normal range, mantissa truncated)
    function automatic logic [31:0] f32_of(input real v);
        logic [63:0] b;
        logic [10:0] ed;
        if (v == 0.0) return 32'd0;
        b  = $realtobits(v);
        ed = b[62:52] - 11'd896;
        return {b[63], ed[7:0], b[51:29]};
    endfunction

    // reference model: plain arithmetic on the angle in units of 2^-16 degree
    function automatic logic [41:0] model(input logic [31:0] a, input logic [4:0] ch, input logic byp);
        longint one = 65536;
        int     e;
        real    r;
        longint m, rr, af;
        logic [1:0] q;
        logic   sn, cn;
        logic [31:0] f;
        if (byp) return {a, ch, 5'b00000};
        e = int'(a[30:23]);
        if (e == 255) return {32'd0, ch, 5'b00001};
        if (e == 0) begin
            r = 0.0;
        end else begin
            // |angle| * 2^16 = significand * 2^(e - 127 - 23 + 16)
            r = real'({1'b1, a[22:0]});
            for (int i = 0; i < e - 134; i++) r = r * 2.0;
            for (int i = 0; i < 134 - e; i++) r = r / 2.0;
        end
        if (r >= 4294967296.0) return {32'd0, ch, 5'b00001};
        m  = longint'($floor(r));
        rr = m % (360 * one);
        if (a[31] && rr != 0) rr = 360 * one - rr;
        q = 2'(rr / (90 * one));
        case (q)
            2'd0: begin af = rr;             sn = 1'b0; cn = 1'b0; end
            2'd1: begin af = 180 * one - rr; sn = 1'b0; cn = 1'b1; end
            2'd2: begin af = rr - 180 * one; sn = 1'b1; cn = 1'b1; end
            default: begin af = 360 * one - rr; sn = 1'b1; cn = 1'b0; end
        endcase
        f = (af == 0) ? 32'd0 : f32_of(real'(af) / 65536.0);
        return {f, ch, q, sn, cn, 1'b0};
    endfunction

    // monitor: latency on each rising out_valid, result on each transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("spurious_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc - acc_q.pop_front()), 64'd11);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    logic [41:0] e;
                    e = exp_q.pop_front();
                    check("out_angle", 64'(out_angle), 64'(e[41:10]));
                    check("tag_flags",
                          64'({out_chrve, out_quadrant, out_sin_neg, out_cos_neg, out_err}),
                          64'(e[9:0]));
                end
            end
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        end
        prev_valid = out_valid;
    end

    // driver: caller is #1 after a rising edge
    task automatic send(input logic [31:0] a, input logic [4:0] ch, input logic byp, input logic [41:0] e);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid  = 1'b1;
        in_angle  = a;
        in_chrve  = ch;
        in_bypass = byp;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic dir(input logic [31:0] a, input logic byp, input logic [31:0] ea,
                       input logic [1:0] q, input logic sn, input logic cn, input logic er);
        logic [4:0] ch;
        ch = 5'($urandom_range(0, 31));
        send(a, ch, byp, {ea, ch, q, sn, cn, er});
        drain(1'b0);
    endtask

    initial begin
        logic [31:0] a, hold_angle;
        logic [9:0]  hold_rest;
        logic [4:0]  ch;
        logic        byp;
        int          n;

        rst = 1'b1; in_valid = 1'b0; in_angle = '0; in_chrve = '0;
        in_bypass = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs",
              64'({out_angle, out_chrve, out_quadrant, out_sin_neg, out_cos_neg, out_err}), 64'd0);

        // directed vectors with hand-derived results
        send(32'h41F00000, 5'b00101, 1'b0, {32'h41F00000, 5'b00101, 2'd0, 1'b0, 1'b0, 1'b0});
        drain(1'b0);
        dir(32'h42F00000, 1'b0, 32'h42700000, 2'd1, 1'b0, 1'b1, 1'b0); // 120
        dir(32'h43A00000, 1'b0, 32'h42200000, 2'd3, 1'b1, 1'b0, 1'b0); // 320
        dir(32'h42B40000, 1'b0, 32'h42B40000, 2'd1, 1'b0, 1'b1, 1'b0); // 90
        dir(32'h43340000, 1'b0, 32'h00000000, 2'd2, 1'b1, 1'b1, 1'b0); // 180
        dir(32'h443B8000, 1'b0, 32'h41F00000, 2'd0, 1'b0, 1'b0, 1'b0); // 750
        dir(32'hC1F00000, 1'b0, 32'h41F00000, 2'd3, 1'b1, 1'b0, 1'b0); // -30
        dir(32'hC2B40000, 1'b0, 32'h42B40000, 2'd3, 1'b1, 1'b0, 1'b0); // -90
        dir(32'h00000000, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b0); // +0
        dir(32'h80000000, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b0); // -0
        dir(32'h7FC00000, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1); // NaN
        dir(32'h47800000, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1); // 65536
        dir(32'h3F19999A, 1'b1, 32'h3F19999A, 2'd0, 1'b0, 1'b0, 1'b0); // bypass 0.6
        dir(32'h7F800000, 1'b1, 32'h7F800000, 2'd0, 1'b0, 1'b0, 1'b0); // bypass Inf

        // backpressure: result held, new sample ignored
        out_ready = 1'b0;
        send(32'h42F00000, 5'b01010, 1'b0, {32'h42700000, 5'b01010, 2'd1, 1'b0, 1'b1, 1'b0});
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_rise", 64'(out_valid), 64'd1);
        hold_angle = out_angle;
        hold_rest  = {out_chrve, out_quadrant, out_sin_neg, out_cos_neg, out_err};
        in_valid = 1'b1; in_angle = 32'h43A00000; in_chrve = 5'b11111;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            check("bp_hold_angle", 64'(out_angle), 64'(hold_angle));
            check("bp_hold_rest",
                  64'({out_chrve, out_quadrant, out_sin_neg, out_cos_neg, out_err}), 64'(hold_rest));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset while the sample is in the modulo loop
        send(32'h443B8000, 5'b00011, 1'b0, 42'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs",
              64'({out_angle, out_chrve, out_quadrant, out_sin_neg, out_cos_neg, out_err}), 64'd0);
        exp_q.delete();
        acc_q.delete();
        rst = 1'b0;
        send(32'h41F00000, 5'b00101, 1'b0, {32'h41F00000, 5'b00101, 2'd0, 1'b0, 1'b0, 1'b0});
        drain(1'b0);

        // randomized vectors against the reference model
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = f32_of(real'($urandom_range(0, 65535)));
                    a[31] = (a != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                1: a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 145)), 23'($urandom)};
                default: a = $urandom;
            endcase
            ch  = 5'($urandom_range(0, 31));
            byp = ($urandom_range(0, 9) == 0);
            send(a, ch, byp, model(a, ch, byp));
            drain(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_angle_reducer.md
Name: cordic_angle_reducer

Overview:
Upstream stage of the CORDIC block. It accepts an IEEE-754 single-precision angle in degrees of any magnitude below 65536. It reduces the angle to the range [0,90] and emits the reduced angle as float32, together with sign-correction flags for sin and cos. The angle feeds the CORDIC z input and the flags go to the output fixup. The 5-bit CHRVE mode tag travels with each sample, and hyperbolic/radian operands can bypass reduction.

Parameters:
FRAC_BITS, 16, fractional bits of the internal unsigned fixed-point magnitude. The integer part is fixed at 16 bits; the datapath is 16+FRAC_BITS wide.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_angle  in  32  float32 angle, degrees
in_chrve  in  5  CHRVE mode tag, passed through
in_bypass  in  1  1 = skip reduction; angle is forwarded unchanged
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts the result
out_angle  out  32  float32 reduced angle in [0,90]
out_chrve  out  5  captured CHRVE tag
out_quadrant  out  2  quadrant of the full-circle residue
out_sin_neg  out  1  downstream must negate sin
out_cos_neg  out  1  downstream must negate cos
out_err  out  1  input was NaN/Inf or |angle| >= 65536

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_angle=0, out_chrve=0, out_quadrant=0, out_sin_neg=0, out_cos_neg=0, out_err=0. Reset in any state aborts the sample in flight; nothing is emitted.
- Handshake: a sample is accepted on an edge with in_valid&in_ready. in_ready=1 only in IDLE, so there is one sample in flight. The result is transferred on an edge with out_valid&out_ready, which returns the block to IDLE. All outputs stay stable while out_valid=1 and out_ready=0.
- FSM: IDLE -> UNPACK -> REDUCE (8 cycles, k=7..0) -> FOLD -> PACK -> DONE -> IDLE.
- Latency: out_valid rises on the 11th edge after the accepting edge. Latency is fixed for every input, including bypass and error cases.
- UNPACK: capture the sign and convert to unsigned Q16.FRAC_BITS magnitude M.
  - The fraction is truncated.
  - exp=255 or unbiased exponent >= 16 sets err.
  - Magnitudes below 2^-FRAC_BITS become 0; denormals are treated as 0.
- REDUCE: restoring modulo. For k=7..0, if M >= 360*2^k then M = M - 360*2^k. The result is R in [0,360).
- FOLD:
  - If the sign is negative and R != 0, then R = 360 - R. -0 is treated as 0.
  - Q0: R < 90. A = R; sin_neg=0, cos_neg=0.
  - Q1: 90 <= R < 180. A = 180 - R; sin_neg=0, cos_neg=1.
  - Q2: 180 <= R < 270. A = R - 180; sin_neg=1, cos_neg=1.
  - Q3: R >= 270. A = 360 - R; sin_neg=1, cos_neg=0.
  - Boundaries: exactly 90 gives Q1 with A=90. Exactly 180 gives Q2 with A=0.
- PACK:
  - Leading-one detect on A. exponent = 127 + (msb_pos - FRAC_BITS); mantissa is truncated.
  - A=0 gives 0x00000000. The output sign is always 0.
- Bypass: out_angle = in_angle bit-exact; quadrant=0, flags=0, err=0. No range check is done.
- Error: out_angle=0, quadrant=0, flags=0, err=1. out_chrve is still passed through.
- Exactness: integer-degree inputs produce exact outputs.

Test Plan:
- Basic angle: in_angle=0x41F00000 (30), out_ready=1. Required: after 11 edges, out_angle=0x41F00000, quadrant=0, sin_neg=0, cos_neg=0, err=0; out_chrve equals in_chrve (5'b00101).
- Quadrant folding:
  - 0x42F00000 (120) -> 0x42700000 (60), quadrant=1, cos_neg=1.
  - 0x43A00000 (320) -> 0x42200000 (40), quadrant=3, sin_neg=1.
  - 0x42B40000 (90) -> 0x42B40000, quadrant=1.
- Wrap and sign:
  - 0x443B8000 (750) -> 0x41F00000 (30), quadrant=0.
  - 0xC1F00000 (-30) -> 0x41F00000, quadrant=3, sin_neg=1.
  - 0x00000000 -> 0x00000000, quadrant=0.
- Errors and bypass:
  - 0x7FC00000 (NaN) -> err=1, out_angle=0.
  - 0x47800000 (65536) -> err=1.
  - in_bypass=1 with 0x3F19999A (0.6) -> out_angle=0x3F19999A, err=0, same latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: outputs stable, in_ready=0, and a new in_valid is ignored. Asserting out_ready returns to IDLE with in_ready=1 on the next edge.
- Reset mid-operation: assert rst during REDUCE. Required: on the next edge all outputs are at reset values and in_ready=1. A following 30° sample completes normally.
